spi_flash_master: RTL and testbench

SPI_FLASH_MASTER -- requirements
Module: spi_flash_master

---
 rtl/spi_flash_master.sv | 120 ++++++++++++
 tb/tb_spi_flash_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_master.sv
// spi_flash_master: bus-mapped SPI mode-0 byte master for a serial flash.
// Define SPI_MASTER_DONE_EN to add a one-cycle done pulse at the end of each byte.
module spi_flash_master #(
    parameter int CLKDIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  logic        sel,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n,
    output logic        busy
`ifdef SPI_MASTER_DONE_EN
    ,
    output logic        done
`endif
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rxs_q, rxs_d;
    logic [7:0]  rx_q, rx_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        tc, fin;
    logic        unused_ok;

    // rd only qualifies the read mux externally; dout is purely combinational
    assign unused_ok = ^{rd, din[15:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rxs_q   <= '0;
            rx_q    <= '0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rxs_q   <= rxs_d;
            rx_q    <= rx_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rxs_d   = rxs_q;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        cs_n_d  = (wr && sel) ? ~din[0] : cs_n_q;
        tc      = cnt_q == 8'(CLKDIV - 1);
        fin     = state_q == HIGH && tc && bit_q == 3'd7;
        case (state_q)
            IDLE: begin
                if (wr && !sel) begin
                    state_d = LOW;
                    tx_d    = din[7:0];
                    mosi_d  = din[7];
                    cnt_d   = '0;
                end
            end
            LOW: begin
                cnt_d = tc ? 8'd0 : cnt_q + 8'd1;
                if (tc) begin
                    state_d = HIGH;
                    rxs_d   = {rxs_q[6:0], miso};
                end
            end
            HIGH: begin
                cnt_d = tc ? 8'd0 : cnt_q + 8'd1;
                if (tc) begin
                    bit_d = bit_q + 3'd1;
                    if (fin) begin
                        state_d = IDLE;
                        rx_d    = rxs_q;
                    end else begin
                        state_d = LOW;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_MASTER_DONE_EN
    logic done_q;
    always_ff @(posedge clk) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= fin;
    end
    assign done = done_q;
`endif

    assign busy = state_q != IDLE;
    assign sck  = state_q == HIGH;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign dout = sel ? {14'd0, ~cs_n_q, busy} : {8'd0, rx_q};
endmodule

// File: tb/tb_spi_flash_master.sv
// tb_spi_flash_master: directed checks of spi_flash_master at CLKDIV=4 and CLKDIV=1.
// Done-pulse checks are compiled in when SPI_MASTER_DONE_EN is defined.
module tb_spi_flash_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0, rd = 1'b0, sel = 1'b0, tgt = 1'b0;
    logic [15:0] din = '0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] dout4, dout1, dout_m;
    logic        sck4, sck1, mosi4, mosi1, cs_n4, cs_n1, busy4, busy1;
    logic        miso4, miso1, wr4, wr1;
    logic        sck_m, mosi_m, busy_m, cs_n_m, done_m;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    // mode 0: loopback, 1: miso tied high, 2: miso tied low
    assign miso4  = mode == 2'd0 ? mosi4 : mode == 2'd1;
    assign miso1  = mode == 2'd0 ? mosi1 : mode == 2'd1;
    assign wr4    = wr & ~tgt;
    assign wr1    = wr & tgt;
    assign dout_m = tgt ? dout1 : dout4;
    assign sck_m  = tgt ? sck1 : sck4;
    assign mosi_m = tgt ? mosi1 : mosi4;
    assign busy_m = tgt ? busy1 : busy4;
    assign cs_n_m = tgt ? cs_n1 : cs_n4;

`ifdef SPI_MASTER_DONE_EN
    logic done4, done1;
    assign done_m = tgt ? done1 : done4;
`else
    assign done_m = 1'b0;
`endif

    spi_flash_master #(.CLKDIV(4)) u4 (
        .clk(clk), .reset(reset), .wr(wr4), .rd(rd), .sel(sel), .din(din), .dout(dout4),
        .sck(sck4), .mosi(mosi4), .miso(miso4), .cs_n(cs_n4), .busy(busy4)
`ifdef SPI_MASTER_DONE_EN
        , .done(done4)
`endif
    );

    spi_flash_master #(.CLKDIV(1)) u1 (
        .clk(clk), .reset(reset), .wr(wr1), .rd(rd), .sel(sel), .din(din), .dout(dout1),
        .sck(sck1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1), .busy(busy1)
`ifdef SPI_MASTER_DONE_EN
        , .done(done1)
`endif
    );

    typedef struct {
        logic       tgt;
        logic [7:0] d;
        logic [1:0] mode;
        logic [7:0] rx;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd_reg(input logic s, output logic [15:0] v);
        sel = s;
        rd  = 1'b1;
        #1 v = dout_m;
        rd  = 1'b0;
    endtask

    task automatic ctl(input logic [15:0] v);
        @(negedge clk);
        sel = 1'b1; din = v; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic run_xfer(input logic [7:0] d, input int inj, input logic [7:0] inj_d,
                            output int cyc, output int rises, output int badsp,
                            output logic [7:0] word, output logic mor, output logic dearly);
        int   last, div;
        logic prev;
        div = tgt ? 1 : 4;
        @(negedge clk);
        sel = 1'b0; din = {8'h00, d}; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        cyc = 0; rises = 0; badsp = 0; word = '0; mor = 1'b0; dearly = 1'b0; prev = 1'b0; last = 0;
        while (busy_m && cyc < 400) begin
            cyc++;
            if (sck_m && !prev) begin
                rises++;
                if (rises > 1 && cyc - last != 2 * div) badsp++;
                last = cyc;
                word = {word[6:0], mosi_m};
            end
            prev   = sck_m;
            mor    = mor | mosi_m;
            dearly = dearly | done_m;
            if (cyc == inj) begin
                wr = 1'b1; sel = 1'b0; din = {8'h00, inj_d};
            end else wr = 1'b0;
            @(negedge clk);
        end
        wr = 1'b0;
    endtask

    initial begin
        int          cyc, rises, badsp, n;
        logic [7:0]  word;
        logic        mor, dearly, dseen;
        logic [15:0] v;

        tbl[0] = '{1'b0, 8'hA5, 2'd0, 8'hA5};
        tbl[1] = '{1'b0, 8'h00, 2'd1, 8'hFF};
        tbl[2] = '{1'b0, 8'hFF, 2'd2, 8'h00};
        tbl[3] = '{1'b0, 8'h3C, 2'd0, 8'h3C};
        tbl[4] = '{1'b0, 8'h81, 2'd1, 8'hFF};
        tbl[5] = '{1'b1, 8'h5A, 2'd0, 8'h5A};
        tbl[6] = '{1'b1, 8'hC3, 2'd2, 8'h00};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy4, 0);
        chk("rst_sck", sck4, 0);
        chk("rst_mosi", mosi4, 0);
        chk("rst_cs_n", cs_n4, 1);
        chk("rst_done", done_m, 0);
        rd_reg(1'b0, v); chk("rst_rx", v, 16'h0000);
        rd_reg(1'b1, v); chk("rst_status", v, 16'h0000);

        for (int i = 0; i < 7; i++) begin
            tgt  = tbl[i].tgt;
            mode = tbl[i].mode;
            run_xfer(tbl[i].d, -1, 8'h00, cyc, rises, badsp, word, mor, dearly);
            chk($sformatf("v%0d_busy_cycles", i), cyc, tgt ? 16 : 64);
            chk($sformatf("v%0d_sck_rises", i), rises, 8);
            chk($sformatf("v%0d_sck_spacing", i), badsp, 0);
            chk($sformatf("v%0d_mosi_word", i), word, tbl[i].d);
            chk($sformatf("v%0d_mosi_any", i), mor, |tbl[i].d);
            chk($sformatf("v%0d_mosi_hold", i), mosi_m, tbl[i].d[0]);
`ifdef SPI_MASTER_DONE_EN
            chk($sformatf("v%0d_done_early", i), dearly, 0);
            chk($sformatf("v%0d_done_at_fall", i), done_m, 1);
`endif
            rd_reg(1'b0, v); chk($sformatf("v%0d_rx", i), v, {8'h00, tbl[i].rx});
            rd_reg(1'b1, v); chk($sformatf("v%0d_status", i), v, 16'h0000);
`ifdef SPI_MASTER_DONE_EN
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done_m, 0);
`endif
        end

        tgt = 1'b0; mode = 2'd0;
        run_xfer(8'h81, 10, 8'h3C, cyc, rises, badsp, word, mor, dearly);
        chk("ignore_busy_cycles", cyc, 64);
        chk("ignore_mosi_word", word, 8'h81);
        rd_reg(1'b0, v); chk("ignore_rx", v, 16'h0081);

        @(negedge clk);
        sel = 1'b0; din = 16'h0012; wr = 1'b1; rd = 1'b1;
        #1 chk("wr_rd_data_prewrite", dout_m, 16'h0081);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("wr_rd_started", busy_m, 1);
        n = 0;
        while (busy_m && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("wr_rd_drain", n < 400, 1);
        rd_reg(1'b0, v); chk("wr_rd_rx", v, 16'h0012);

        @(negedge clk);
        sel = 1'b1; din = 16'h0001; wr = 1'b1; rd = 1'b1;
        #1 chk("wr_rd_status_prewrite", dout_m, 16'h0000);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("ctl_cs_low", cs_n_m, 0);
        rd_reg(1'b1, v); chk("ctl_status_sel", v, 16'h0002);
        ctl(16'h0000);
        chk("ctl_cs_high", cs_n_m, 1);
        rd_reg(1'b1, v); chk("ctl_status_desel", v, 16'h0000);

        ctl(16'h0001);
        @(negedge clk);
        sel = 1'b0; din = 16'h00A5; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (19) @(negedge clk);
        chk("rst_mid_busy_before", busy_m, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dseen = done_m;
        chk("rst_mid_busy", busy_m, 0);
        chk("rst_mid_sck", sck_m, 0);
        chk("rst_mid_cs_n", cs_n_m, 1);
        chk("rst_mid_mosi", mosi_m, 0);
        rd_reg(1'b0, v); chk("rst_mid_rx", v, 16'h0000);
        repeat (70) begin
            @(negedge clk);
            dseen = dseen | done_m;
        end
        chk("rst_mid_no_restart", busy_m, 0);
        chk("rst_mid_no_done", dseen, 0);

        @(negedge clk);
        reset = 1'b1; sel = 1'b0; din = 16'h00FF; wr = 1'b1;
        @(negedge clk);
        reset = 1'b0; wr = 1'b0;
        chk("rst_prio_busy", busy_m, 0);
        @(negedge clk);
        chk("rst_prio_busy_next", busy_m, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
